// File: rtl/shell_reply_tx_if.sv
// Reply request channel between the shell command executor and the reply
// transmitter. Signal names are seen from the transmitter side.
interface shell_reply_tx_if;
  logic        i_Valid;
  logic        o_Ready;
  logic [1:0]  i_Mode;
  logic [15:0] i_Addr;
  logic [15:0] i_Data;
  logic        o_Done;

  // Command executor side: issues requests, observes ready/done.
  modport master (
    output i_Valid,
    output i_Mode,
    output i_Addr,
    output i_Data,
    input  o_Ready,
    input  o_Done
  );

  // Reply transmitter side.
  modport slave (
    input  i_Valid,
    input  i_Mode,
    input  i_Addr,
    input  i_Data,
    output o_Ready,
    output o_Done
  );
endinterface

// File: rtl/shell_reply_tx.sv
// Shell reply transmitter: takes one reply request (mode, address, data),
// formats it as an ASCII line with uppercase hex digits and sends it
// byte by byte as 8N1 on UART_TX. Bytes are generated on demand from the
// latched request, so no message buffer is needed.
module shell_reply_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic             CLK,
  input  logic             RST,
  shell_reply_tx_if.slave  bus,
  output logic             UART_TX
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  localparam logic [1:0] MODE_DATA      = 2'd0;
  localparam logic [1:0] MODE_ADDR_DATA = 2'd1;
  localparam logic [1:0] MODE_OK        = 2'd2;
  localparam logic [1:0] MODE_ERR       = 2'd3;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_K     = 8'h4B;
  localparam logic [7:0] CH_QUEST = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Nibble 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
  function automatic logic [7:0] f_hex(input logic [3:0] nib);
    logic [7:0] ch;
    if (nib < 4'd10) begin
      ch = 8'h30 + {4'h0, nib};
    end else begin
      ch = 8'h37 + {4'h0, nib};
    end
    return ch;
  endfunction

  // Select a nibble of a 16-bit word, index 0 being the most significant.
  function automatic logic [3:0] f_nib(input logic [15:0] word, input logic [1:0] sel);
    logic [3:0] nib;
    case (sel)
      2'd0:    nib = word[15:12];
      2'd1:    nib = word[11:8];
      2'd2:    nib = word[7:4];
      2'd3:    nib = word[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // Index of the final byte of the message for a given mode.
  function automatic logic [3:0] f_last_idx(input logic [1:0] mode);
    logic [3:0] last;
    case (mode)
      MODE_DATA:      last = 4'd5;
      MODE_ADDR_DATA: last = 4'd11;
      MODE_OK:        last = 4'd3;
      MODE_ERR:       last = 4'd2;
      default:        last = 4'd2;
    endcase
    return last;
  endfunction

  // Byte at position idx of the formatted reply line.
  function automatic logic [7:0] f_msg_byte(
    input logic [1:0]  mode,
    input logic [15:0] addr,
    input logic [15:0] data,
    input logic [3:0]  idx
  );
    logic [7:0] ch;
    logic [3:0] rel;
    rel = idx - 4'd6;
    ch  = CH_LF;
    case (mode)
      MODE_DATA: begin
        case (idx)
          4'd0, 4'd1, 4'd2, 4'd3: ch = f_hex(f_nib(data, idx[1:0]));
          4'd4:                   ch = CH_CR;
          default:                ch = CH_LF;
        endcase
      end
      MODE_ADDR_DATA: begin
        case (idx)
          4'd0, 4'd1, 4'd2, 4'd3: ch = f_hex(f_nib(addr, idx[1:0]));
          4'd4:                   ch = CH_COLON;
          4'd5:                   ch = CH_SPACE;
          4'd6, 4'd7, 4'd8, 4'd9: ch = f_hex(f_nib(data, rel[1:0]));
          4'd10:                  ch = CH_CR;
          default:                ch = CH_LF;
        endcase
      end
      MODE_OK: begin
        case (idx)
          4'd0:    ch = CH_O;
          4'd1:    ch = CH_K;
          4'd2:    ch = CH_CR;
          default: ch = CH_LF;
        endcase
      end
      MODE_ERR: begin
        case (idx)
          4'd0:    ch = CH_QUEST;
          4'd1:    ch = CH_CR;
          default: ch = CH_LF;
        endcase
      end
      default: ch = CH_LF;
    endcase
    return ch;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [3:0]        r_byte, w_byte_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [15:0]       r_addr, w_addr_nxt;
  logic [15:0]       r_data, w_data_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_done, w_done_nxt;

  logic              w_accept;
  logic              w_baud_end;
  logic [3:0]        w_last_idx;
  logic [3:0]        w_byte_inc;

  assign w_accept   = bus.i_Valid && r_ready;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_last_idx = f_last_idx(r_mode);
  assign w_byte_inc = r_byte + 4'd1;

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_shift_nxt = r_shift;
    w_mode_nxt  = r_mode;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;

    case (r_state)
      // DONE behaves like IDLE for acceptance so a waiting request goes
      // out with only a single idle-high cycle between messages.
      ST_IDLE, ST_DONE: begin
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          w_mode_nxt  = bus.i_Mode;
          w_addr_nxt  = bus.i_Addr;
          w_data_nxt  = bus.i_Data;
          w_shift_nxt = f_msg_byte(bus.i_Mode, bus.i_Addr, bus.i_Data, 4'd0);
          w_byte_nxt  = 4'd0;
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = '0;
          w_tx_nxt    = 1'b0;
          w_ready_nxt = 1'b0;
          w_state_nxt = ST_START;
        end else begin
          w_baud_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end

      ST_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_byte == w_last_idx) begin
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_byte_nxt  = w_byte_inc;
            w_shift_nxt = f_msg_byte(r_mode, r_addr, r_data, w_byte_inc);
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end

      default: begin
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
        w_baud_nxt  = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_byte  <= 4'd0;
      r_shift <= 8'h00;
      r_mode  <= 2'd0;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_shift <= w_shift_nxt;
      r_mode  <= w_mode_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign UART_TX     = r_tx;
  assign bus.o_Ready = r_ready;
  assign bus.o_Done  = r_done;

endmodule
